dram_hazard_ctl: RTL and testbench

Data-memory access scheduler for the bfcpu2 pipeline. It sits between the data-fetch and data-writeback stages and the dual-port DRAM (one read port, one write port). It keeps an in-order scoreboard of addresses that have been fetched but not yet written back. A data-fetch read that targets a pending write address is held off until that write has landed, so the pipeline never reads a stale cell (read-after-write on `+`/`-` sequences).

---
 rtl/dram_hazard_ctl_pkg.sv | 10 +
 rtl/dram_hazard_ctl_cam.sv | 56 +++++
 rtl/dram_hazard_ctl.sv | 131 +++++++++++++
 tb/tb_dram_hazard_ctl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dram_hazard_ctl_pkg.sv
// Shared constants and helpers for the DRAM hazard scheduler.
package dram_hazard_ctl_pkg;

    localparam int DHAZ_DEPTH_DEFAULT = 4;

    function automatic int dhaz_ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/dram_hazard_ctl_cam.sv
// Scoreboard entry array: valid+address per slot, parallel compare against the read address.
module dram_hazard_cam
    import dram_hazard_ctl_pkg::*;
#(
    parameter int DEPTH    = DHAZ_DEPTH_DEFAULT,
    parameter int DA_WIDTH = 12,
    parameter int PW       = dhaz_ptr_w(DEPTH)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                alloc_i,
    input  logic [PW-1:0]       alloc_idx_i,
    input  logic [DA_WIDTH-1:0] alloc_addr_i,
    input  logic                retire_i,
    input  logic [PW-1:0]       retire_idx_i,
    input  logic [DA_WIDTH-1:0] cmp_addr_i,
    input  logic [PW-1:0]       head_idx_i,
    output logic [DEPTH-1:0]    hit_vec_o,
    output logic                head_hit_o,
    output logic [DA_WIDTH-1:0] head_addr_o
);

    logic [DEPTH-1:0]    vld_q, vld_d;
    logic [DA_WIDTH-1:0] addr_q [DEPTH];
    logic [DA_WIDTH-1:0] addr_d [DEPTH];

    // Retire clears first; allocation never targets the retiring slot.
    always_comb begin
        vld_d  = vld_q;
        addr_d = addr_q;
        if (retire_i) vld_d[retire_idx_i] = 1'b0;
        if (alloc_i) begin
            vld_d[alloc_idx_i]  = 1'b1;
            addr_d[alloc_idx_i] = alloc_addr_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q <= '0;
            for (int i = 0; i < DEPTH; i++) addr_q[i] <= '0;
        end else begin
            vld_q  <= vld_d;
            addr_q <= addr_d;
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++)
            hit_vec_o[i] = vld_q[i] && (addr_q[i] == cmp_addr_i);
    end

    assign head_hit_o  = hit_vec_o[head_idx_i];
    assign head_addr_o = addr_q[head_idx_i];

endmodule

// File: rtl/dram_hazard_ctl.sv
// Read-after-write hazard scheduler in front of the dual-port data DRAM.
// Optional head-entry forwarding when DHAZARD_FORWARD_EN is defined.
module dram_hazard_ctl
    import dram_hazard_ctl_pkg::*;
#(
    parameter int DA_WIDTH = 12,
    parameter int DD_WIDTH = 8,
    parameter int DEPTH    = DHAZ_DEPTH_DEFAULT
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                rd_req,
    input  logic [DA_WIDTH-1:0] rd_addr,
    input  logic                rd_wr_intent,
    output logic                rd_grant,
    output logic [DD_WIDTH-1:0] rd_data,
    output logic                dram_rce,
    output logic [DA_WIDTH-1:0] dram_ra,
    input  logic [DD_WIDTH-1:0] dram_rq,
    input  logic                wb_valid,
    input  logic [DA_WIDTH-1:0] wb_addr,
    input  logic [DD_WIDTH-1:0] wb_data,
    output logic                dram_wce,
    output logic [DA_WIDTH-1:0] dram_wa,
    output logic [DD_WIDTH-1:0] dram_wd,
    output logic                busy,
    output logic                full,
    output logic                order_err
);

    localparam int PW = dhaz_ptr_w(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [PW-1:0]       head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                err_q, err_d;
    logic                gnt_q;
    logic [DD_WIDTH-1:0] rdat_q;
    logic [DEPTH-1:0]    hit_vec;
    logic                head_hit;
    logic [DA_WIDTH-1:0] head_addr;
    logic                fwd, stall, alloc, retire;

    dram_hazard_cam #(
        .DEPTH    (DEPTH),
        .DA_WIDTH (DA_WIDTH),
        .PW       (PW)
    ) u_cam (
        .clk          (clk),
        .reset        (reset),
        .alloc_i      (alloc),
        .alloc_idx_i  (tail_q),
        .alloc_addr_i (rd_addr),
        .retire_i     (retire),
        .retire_idx_i (head_q),
        .cmp_addr_i   (rd_addr),
        .head_idx_i   (head_q),
        .hit_vec_o    (hit_vec),
        .head_hit_o   (head_hit),
        .head_addr_o  (head_addr)
    );

    assign busy      = (cnt_q != '0);
    assign full      = (cnt_q == FULL_CNT);
    assign order_err = err_q;

    assign stall    = (|hit_vec) & ~fwd;
    assign rd_grant = ~reset & rd_req & ~stall & ~(rd_wr_intent & full);
    assign alloc    = rd_grant & rd_wr_intent;
    assign retire   = ~reset & wb_valid & busy;

    assign dram_rce = rd_grant;
    assign dram_ra  = rd_addr;
    assign dram_wce = wb_valid & ~reset;
    assign dram_wa  = wb_addr;
    assign dram_wd  = wb_data;

    always_comb begin
        head_d = head_q + PW'(retire);
        tail_d = tail_q + PW'(alloc);
        cnt_d  = cnt_q + CW'(alloc) - CW'(retire);
        err_d  = err_q;
        if (wb_valid && (!busy || head_addr != wb_addr)) err_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
            err_q  <= 1'b0;
            gnt_q  <= 1'b0;
            rdat_q <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
            err_q  <= err_d;
            gnt_q  <= rd_grant;
            rdat_q <= rd_data;
        end
    end

`ifdef DHAZARD_FORWARD_EN
    logic                fwd_q;
    logic [DD_WIDTH-1:0] fdat_q;
    logic [DEPTH-1:0]    head_oh;

    // Only a lone head hit retiring this very cycle may bypass the DRAM.
    assign head_oh = DEPTH'(1) << head_q;
    assign fwd = wb_valid & (wb_addr == rd_addr) & head_hit
               & ~|(hit_vec & ~head_oh);

    always_ff @(posedge clk) begin
        if (reset) begin
            fwd_q  <= 1'b0;
            fdat_q <= '0;
        end else begin
            fwd_q  <= rd_grant & fwd;
            fdat_q <= wb_data;
        end
    end

    assign rd_data = gnt_q ? (fwd_q ? fdat_q : dram_rq) : rdat_q;
`else
    assign fwd     = 1'b0;
    assign rd_data = gnt_q ? dram_rq : rdat_q;
`endif

endmodule

// File: tb/tb_dram_hazard_ctl.sv
// Randomized scoreboard bench for dram_hazard_ctl against a queue-based reference model.
module tb_dram_hazard_ctl;

    localparam int AW    = 12;
    localparam int DW    = 8;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          rd_req;
    logic [AW-1:0] rd_addr;
    logic          rd_wr_intent;
    logic          rd_grant;
    logic [DW-1:0] rd_data;
    logic          dram_rce;
    logic [AW-1:0] dram_ra;
    logic [DW-1:0] dram_rq;
    logic          wb_valid;
    logic [AW-1:0] wb_addr;
    logic [DW-1:0] wb_data;
    logic          dram_wce;
    logic [AW-1:0] dram_wa;
    logic [DW-1:0] dram_wd;
    logic          busy;
    logic          full;
    logic          order_err;

    always #5 clk = ~clk;

    dram_hazard_ctl #(
        .DA_WIDTH (AW),
        .DD_WIDTH (DW),
        .DEPTH    (DEPTH)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .rd_req       (rd_req),
        .rd_addr      (rd_addr),
        .rd_wr_intent (rd_wr_intent),
        .rd_grant     (rd_grant),
        .rd_data      (rd_data),
        .dram_rce     (dram_rce),
        .dram_ra      (dram_ra),
        .dram_rq      (dram_rq),
        .wb_valid     (wb_valid),
        .wb_addr      (wb_addr),
        .wb_data      (wb_data),
        .dram_wce     (dram_wce),
        .dram_wa      (dram_wa),
        .dram_wd      (dram_wd),
        .busy         (busy),
        .full         (full),
        .order_err    (order_err)
    );

    function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
        return DW'(a * 7 + 3);
    endfunction

    // DRAM model: synchronous read-first, unwritten cells hold init_val
    logic [DW-1:0] mem [4096];
    logic          seen [4096];
    always @(posedge clk) begin
        if (dram_rce)
            dram_rq <= (seen[dram_ra] === 1'b1) ? mem[dram_ra] : init_val(dram_ra);
        if (dram_wce) begin
            mem[dram_wa]  <= dram_wd;
            seen[dram_wa] <= 1'b1;
        end
    end

    typedef struct {
        bit          gnt;
        bit          busy;
        bit          full;
        bit          err;
        bit          wce;
        logic [AW-1:0] ra;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        logic [DW-1:0] dat;
    } rec_t;

    rec_t exq[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (exq.size() > 0) begin
            rec_t r;
            r = exq.pop_front();
            chk("rd_grant", 32'(rd_grant), 32'(r.gnt));
            chk("dram_rce", 32'(dram_rce), 32'(r.gnt));
            chk("dram_ra", 32'(dram_ra), 32'(r.ra));
            chk("dram_wce", 32'(dram_wce), 32'(r.wce));
            chk("dram_wa", 32'(dram_wa), 32'(r.wa));
            chk("dram_wd", 32'(dram_wd), 32'(r.wd));
            chk("busy", 32'(busy), 32'(r.busy));
            chk("full", 32'(full), 32'(r.full));
            chk("order_err", 32'(order_err), 32'(r.err));
            chk("rd_data", 32'(rd_data), 32'(r.dat));
        end
    end

    // Reference model state: pending write addresses in program order
    logic [AW-1:0] mq[$];
    bit            merr = 0;
    logic [DW-1:0] ldat = '0;
    logic [DW-1:0] ref_mem [4096];
    bit            ref_seen [4096];

    function automatic logic [DW-1:0] rmem(input logic [AW-1:0] a);
        return ref_seen[a] ? ref_mem[a] : init_val(a);
    endfunction

    task automatic cyc(input bit rst, input bit req, input logic [AW-1:0] a,
                       input bit it, input bit wv, input logic [AW-1:0] wa,
                       input logic [DW-1:0] wd);
        rec_t r;
        int   hits;
        bit   fw;
        bit   g;
        logic [DW-1:0] nd;
        @(posedge clk);
        #1;
        reset = rst; rd_req = req; rd_addr = a; rd_wr_intent = it;
        wb_valid = wv; wb_addr = wa; wb_data = wd;
        hits = 0;
        foreach (mq[i]) if (mq[i] == a) hits++;
        fw = 0;
`ifdef DHAZARD_FORWARD_EN
        fw = wv && (wa == a) && (mq.size() > 0) && (mq[0] == a) && (hits == 1);
`endif
        g = !rst && req && (hits == 0 || fw) && !(it && mq.size() == DEPTH);
        r.gnt = g; r.ra = a; r.wce = wv && !rst; r.wa = wa; r.wd = wd;
        r.busy = (mq.size() != 0); r.full = (mq.size() == DEPTH);
        r.err = merr; r.dat = ldat;
        exq.push_back(r);
        if (rst) begin
            mq.delete(); merr = 0; ldat = '0;
        end else begin
            nd = fw ? wd : rmem(a);
            if (wv) begin
                if (mq.size() == 0) merr = 1;
                else begin
                    if (mq[0] != wa) merr = 1;
                    void'(mq.pop_front());
                end
                ref_mem[wa] = wd; ref_seen[wa] = 1;
            end
            if (g && it) mq.push_back(a);
            if (g) ldat = nd;
        end
    endtask

    task automatic idle();
        cyc(0, 0, '0, 0, 0, '0, '0);
    endtask
    task automatic rd(input logic [AW-1:0] a, input bit it);
        cyc(0, 1, a, it, 0, '0, '0);
    endtask
    task automatic wb(input logic [AW-1:0] a, input logic [DW-1:0] d);
        cyc(0, 0, '0, 0, 1, a, d);
    endtask
    task automatic drain();
        while (mq.size() > 0) wb(mq[0], DW'($urandom));
    endtask

    initial begin
        reset = 1; rd_req = 0; rd_addr = '0; rd_wr_intent = 0;
        wb_valid = 0; wb_addr = '0; wb_data = '0;
        @(posedge clk);
        cyc(1, 0, '0, 0, 0, '0, '0);
        idle();
        // dependent read
        rd(12'h005, 1);
        rd(12'h005, 0);
        rd(12'h005, 0);
        cyc(0, 1, 12'h005, 0, 1, 12'h005, 8'h01);
        rd(12'h005, 0);
        idle();
        // independent read
        rd(12'h005, 1);
        rd(12'h006, 1);
        drain();
        // fill
        for (int i = 0; i < 4; i++) rd(AW'(12'h010 + i), 1);
        rd(12'h014, 1);
        rd(12'h020, 0);
        cyc(0, 1, 12'h014, 1, 1, 12'h010, 8'h33);
        drain();
        // forwarding
        rd(12'h007, 1);
        cyc(0, 1, 12'h007, 0, 1, 12'h007, 8'hAB);
        rd(12'h007, 0);
        idle();
        // order errors
        rd(12'h005, 1);
        wb(12'h009, 8'h44);
        idle();
        wb(12'h00A, 8'h55);
        rd(12'h005, 0);
        idle();
        // reset mid-operation
        rd(12'h030, 1); rd(12'h031, 1); rd(12'h032, 1);
        cyc(1, 0, '0, 0, 0, '0, '0);
        rd(12'h031, 0);
        idle();
        // random legal traffic
        for (int n = 0; n < 1500; n++) begin
            bit            rq, it, wv, rs;
            logic [AW-1:0] a, wa;
            rs = ($urandom_range(0, 99) == 0);
            rq = ($urandom_range(0, 9) < 7);
            it = $urandom_range(0, 1) == 1;
            a  = AW'(12'h040 + $urandom_range(0, 7));
            wv = (mq.size() > 0) && ($urandom_range(0, 9) < 4) && !rs;
            wa = wv ? mq[0] : AW'($urandom_range(0, 4095));
            cyc(rs, rq && !rs, a, it, wv, wa, DW'($urandom));
        end
        drain();
        idle();
        repeat (3) @(posedge clk);
        if (exq.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d leftover expected 0", exq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
